uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//    Byte queue feeding an 8N1 UART transmitter. Bytes are queued on any rising
//    edge where tx_valid_i and tx_ready_o are both high. The transmitter pops
//    the head of the queue from IDLE, sends start bit, eight data bits LSB
//    first and one stop bit, each CLKS_PER_BIT clocks long, and returns to IDLE
//    for exactly one clock before the next frame.
//
// Parameters
//    CLKS_PER_BIT : clocks per serial bit (2..65535)
//    FIFO_DEPTH   : queue depth (2, 4, 8 or 16)
//
// Ports
//    clk_i          : system clock, all state updates on the rising edge
//    rst_ni         : asynchronous active-low reset
//    tx_data_i      : byte offered for transmission
//    tx_valid_i     : tx_data_i is valid
//    tx_ready_o     : queue accepts a byte on this edge
//    uart_rxd_out_o : registered serial line to the host, idle high
//    tx_busy_o      : transmitter is not in IDLE
//    fifo_count_o   : bytes queued, not counting the byte being sent
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          uart_rxd_out_o,
   output logic                          tx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int             AW         = $clog2(FIFO_DEPTH);
   localparam int             CW         = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [15:0]    BIT_LAST_C = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   // transmitter state
   state_e        state_q, state_d;
   logic [15:0]   cnt_q,   cnt_d;
   logic [2:0]    idx_q,   idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          line_q,  line_d;

   // byte queue
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic          push;
   logic          pop;

   // The transmitter takes the head of the queue whenever it sits in IDLE
   // with something queued.
   assign pop = (state_q == IDLE) && (count_q != '0);

   // A full queue still accepts a byte on the edge that pops the head, so the
   // freed slot is refilled in the same cycle and the count stays at depth.
   assign tx_ready_o = (count_q < DEPTH_C) || pop;
   assign push       = tx_valid_i && tx_ready_o;

   assign uart_rxd_out_o = line_q;
   assign tx_busy_o      = (state_q != IDLE);
   assign fifo_count_o   = count_q;

   // ---------------------------------------------------------------------------
   // Queue storage: no reset, contents are only meaningful below count_q.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Queue pointers and occupancy. Pointers wrap naturally at the power-of-two
   // depth; simultaneous push and pop leave the count unchanged.
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Transmitter next state. line_d is the value the line takes after the
   // edge, so the serial output is a plain flop with no path from any input.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      line_d  = line_q;

      case (state_q)
         IDLE: begin
            line_d = 1'b1;
            cnt_d  = '0;
            idx_d  = '0;
            if (pop) begin
               // Copy the head so later writes cannot disturb this frame.
               shreg_d = mem_q[rd_ptr_q];
               line_d  = 1'b0;
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == BIT_LAST_C) begin
               cnt_d   = '0;
               idx_d   = '0;
               line_d  = shreg_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST_C) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  line_d  = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  line_d = shreg_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == BIT_LAST_C) begin
               cnt_d   = '0;
               line_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            line_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset aborts any frame and empties the queue at once.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         line_q   <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         line_q   <= line_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
